// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port data memory between N_REQ requesters.
//   Requester 0 is the CPU load/store path and requester 1 is the DMA/debug port.
//   Each access takes three cycles: IDLE samples the requests, ISSUE drives the
//   memory and pulses gnt, and RESP pulses rvalid (and err) with the load result.
//   Stores are replicated across the byte lanes. Loads are extracted by address
//   and then sign- or zero-extended.
//   Optional feature: define DATA_ARB_ROUND_ROBIN_EN for round-robin arbitration.
//   Without it, fixed priority applies and the lowest index always wins.
module data_mem_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     we,
    input  logic [32*N_REQ-1:0]  addr,
    input  logic [32*N_REQ-1:0]  wdata,
    input  logic [3*N_REQ-1:0]   size,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     rvalid,
    output logic [31:0]          rdata,
    output logic [N_REQ-1:0]     err,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [3:0]           mem_be,
    output logic [29:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   winner_q, winner_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        size_q, size_d;
    logic              err_q, err_d;
    logic              accept;

`ifdef DATA_ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0]   last_q;
    int                cand;
`endif

    // Illegal size codes, stores with an unsigned size, and misaligned halfword or word accesses.
    function automatic logic access_err(input logic st, input logic [2:0] sz, input logic [1:0] a);
        logic e;
        case (sz)
            SZ_B:    e = 1'b0;
            SZ_H:    e = a[0];
            SZ_W:    e = (a != 2'b00);
            SZ_BU:   e = st;
            SZ_HU:   e = st | a[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    assign accept = (state_q == IDLE) && (|req);

    // Pick the winner, gather its request fields, and step the access FSM.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d  = state_q;
        winner_d = '0;
        we_d     = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        size_d   = '0;
`ifdef DATA_ARB_ROUND_ROBIN_EN
        cand     = 0;
        // Scan from the requester after the last grant. The nearest active requester wins.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = int'(last_q) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if ((i == cand) && req[i]) winner_d = IDXW'(i);
            end
        end
`else
        // Fixed priority: the scan runs downward, so the lowest active index is assigned last and wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) winner_d = IDXW'(i);
        end
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (winner_d == IDXW'(i)) begin
                we_d    = we[i];
                addr_d  = addr[32*i +: 32];
                wdata_d = wdata[32*i +: 32];
                size_d  = size[3*i +: 3];
            end
        end
        err_d = access_err(we_d, size_d, addr_d[1:0]);

        case (state_q)
            IDLE:    if (|req) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks let every register see the pre-edge values of its peers.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture the winning access when IDLE samples a request. The later req level is ignored.
    always_ff @(posedge clk) begin
        // NOTE: these datapath registers need no reset, because every output they feed is gated by state.
        if (accept) begin
            winner_q <= winner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            err_q    <= err_d;
        end
    end

`ifdef DATA_ARB_ROUND_ROBIN_EN
    // Arbitration pointer: after reset it points at the last index, so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!reset)      last_q <= IDXW'(N_REQ - 1);
        else if (accept) last_q <= winner_d;
    end
`endif

    // Memory strobes, grant and response pulses, and load formatting, all decoded from the latched access.
    always_comb begin
        logic       issue;
        logic       resp;
        logic [3:0] be;
        logic [31:0] lanes;
        logic [7:0] lane_b;
        logic [15:0] lane_h;
        logic [31:0] load;

        issue = (state_q == ISSUE);
        resp  = (state_q == RESP);

        case (size_q)
            SZ_B, SZ_BU: be = 4'b0001 << addr_q[1:0];
            SZ_H, SZ_HU: be = 4'b0011 << {addr_q[1], 1'b0};
            default:     be = 4'b1111;
        endcase

        case (size_q)
            SZ_B, SZ_BU: lanes = {4{wdata_q[7:0]}};
            SZ_H, SZ_HU: lanes = {2{wdata_q[15:0]}};
            default:     lanes = wdata_q;
        endcase

        case (addr_q[1:0])
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (size_q)
            SZ_B:    load = {{24{lane_b[7]}}, lane_b};
            SZ_BU:   load = {24'h0, lane_b};
            SZ_H:    load = {{16{lane_h[15]}}, lane_h};
            SZ_HU:   load = {16'h0, lane_h};
            default: load = mem_rdata;
        endcase

        gnt    = '0;
        rvalid = '0;
        err    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i]    = issue && (winner_q == IDXW'(i));
            rvalid[i] = resp && (winner_q == IDXW'(i));
            err[i]    = resp && err_q && (winner_q == IDXW'(i));
        end

        mem_en    = issue && !err_q;
        mem_we    = issue && !err_q && we_q;
        mem_be    = (issue && !err_q) ? be : 4'b0000;
        mem_addr  = issue ? addr_q[31:2] : 30'h0;
        mem_wdata = issue ? lanes : 32'h0;
        rdata     = (resp && !err_q && !we_q) ? load : 32'h0;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Drives data_mem_arbiter with directed and randomized accesses. It also holds
//   a small word memory behind the DUT and a byte-level reference memory that
//   predicts every load. The same file builds with or without
//   DATA_ARB_ROUND_ROBIN_EN.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a_addr  [2];
    logic [31:0] a_wdata [2];
    logic [2:0]  a_size  [2];
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [5:0]  size;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    assign addr  = {a_addr[1], a_addr[0]};
    assign wdata = {a_wdata[1], a_wdata[0]};
    assign size  = {a_size[1], a_size[0]};

    data_mem_arbiter #(.N_REQ(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .size      (size),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the arbiter: byte-enabled writes, and read data one cycle after mem_en.
    logic [31:0] env_mem [64];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int j = 0; j < 4; j++)
                if (mem_we && mem_be[j]) env_mem[mem_addr[5:0]][8*j +: 8] <= mem_wdata[8*j +: 8];
            mem_rdata <= env_mem[mem_addr[5:0]];
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: a flat byte memory, plus arbitration history.
    logic [7:0] ref_bytes [256];
    bit         last_grant;

    // What run_access saw on the DUT outputs.
    logic [1:0]  obs_gnt, obs_rv, obs_err;
    int          obs_gnt_cyc, obs_rv_cyc;
    logic        obs_en, obs_we, obs_strobe_resp;
    logic [3:0]  obs_be;
    logic [29:0] obs_maddr;
    logic [31:0] obs_mwdata, obs_rdata;

    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_err(input logic w, input logic [2:0] s, input logic [31:0] a);
        int n = nbytes(s);
        if (n == 0) return 1'b1;
        if (s[2] && w) return 1'b1;
        return (int'(a[7:0]) % n) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] s, input logic [31:0] a);
        logic [3:0] be = '0;
        for (int k = 0; k < nbytes(s); k++) be[int'(a[1:0]) + k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] s, input logic [31:0] d);
        logic [31:0] v = '0;
        int n = nbytes(s);
        for (int j = 0; j < 4; j++) v = v | (((d >> (8 * (j % n))) & 32'hFF) << (8 * j));
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] s, input logic [31:0] a);
        logic [31:0] v = '0;
        int n = nbytes(s);
        for (int k = 0; k < n; k++) v = v | (32'(ref_bytes[int'(a[7:0]) + k]) << (8 * k));
        if (!s[2] && n < 4 && ((v >> (8 * n - 1)) & 32'h1) == 32'h1) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < nbytes(s); k++) ref_bytes[int'(a[7:0]) + k] = 8'((d >> (8 * k)) & 32'hFF);
    endtask

    task automatic set_port(input bit r, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] s);
        we[r]      = w;
        a_addr[r]  = a;
        a_wdata[r] = d;
        a_size[r]  = s;
    endtask

    // Called at a negedge while the DUT is idle. Raises req, records the grant and
    // response cycles, and returns at a later negedge with the DUT idle again.
    task automatic run_access(input logic [1:0] mask);
        obs_gnt = 'x; obs_rv = 'x; obs_err = 'x; obs_en = 1'bx; obs_we = 1'bx;
        obs_be = 'x; obs_maddr = 'x; obs_mwdata = 'x; obs_rdata = 'x; obs_strobe_resp = 1'bx;
        obs_gnt_cyc = -1; obs_rv_cyc = -1;
        req = mask;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (gnt != 2'b00 && obs_gnt_cyc < 0) begin
                obs_gnt = gnt; obs_gnt_cyc = cyc; obs_en = mem_en; obs_we = mem_we;
                obs_be = mem_be; obs_maddr = mem_addr; obs_mwdata = mem_wdata;
                req = 2'b00;
            end
            if (rvalid != 2'b00) begin
                obs_rv = rvalid; obs_rv_cyc = cyc; obs_err = err; obs_rdata = rdata;
                obs_strobe_resp = mem_en | mem_we | (|mem_be);
                break;
            end
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        req   = 2'b00;
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
        last_grant = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 2'b11;
        set_port(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 3'b010);
        set_port(1'b1, 1'b0, 32'h0000_0020, 32'h0, 3'b010);
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, rvalid, err, rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== '0)
            begin errors++; $display("FAIL reset_outputs: got gnt=%b rv=%b err=%b rdata=%h en=%b we=%b be=%b maddr=%h mwd=%h, all zero required",
                gnt, rvalid, err, rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata); end
        req   = 2'b00;
        reset = 1'b1;
        last_grant = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt, rvalid, err, rdata, mem_en, mem_we, mem_be} !== '0)
            begin errors++; $display("FAIL idle_after_reset: got gnt=%b rv=%b en=%b be=%b, all zero required", gnt, rvalid, mem_en, mem_be); end
    endtask

    task automatic test_word_store_load();
        set_port(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010);
        run_access(2'b01);
        model_store(3'b010, 32'h10, 32'hDEAD_BEEF);
        checks++; if (obs_gnt !== 2'b01 || obs_gnt_cyc != 1) begin errors++; $display("FAIL sw_gnt: got %b at cycle %0d, need 01 at cycle 1", obs_gnt, obs_gnt_cyc); end
        checks++; if ({obs_en, obs_we} !== 2'b11) begin errors++; $display("FAIL sw_strobe: got en/we=%b%b, need 11", obs_en, obs_we); end
        checks++; if (obs_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b, need 1111", obs_be); end
        checks++; if (obs_maddr !== 30'h4) begin errors++; $display("FAIL sw_maddr: got %h, need 4", obs_maddr); end
        checks++; if (obs_mwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h, need deadbeef", obs_mwdata); end
        checks++; if (obs_rv !== 2'b01 || obs_rv_cyc != 2 || obs_err !== 2'b00 || obs_rdata !== 32'h0)
            begin errors++; $display("FAIL sw_resp: got rv=%b cyc=%0d err=%b rdata=%h, need 01/2/00/0", obs_rv, obs_rv_cyc, obs_err, obs_rdata); end
        checks++; if (obs_strobe_resp !== 1'b0) begin errors++; $display("FAIL sw_resp_strobe: got %b, need 0", obs_strobe_resp); end

        set_port(1'b0, 1'b0, 32'h0000_0010, 32'h0, 3'b010);
        run_access(2'b01);
        checks++; if ({obs_en, obs_we} !== 2'b10) begin errors++; $display("FAIL lw_strobe: got en/we=%b%b, need 10", obs_en, obs_we); end
        checks++; if (obs_rv !== 2'b01 || obs_rv_cyc != 2 || obs_rdata !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL lw_rdata: got rv=%b cyc=%0d rdata=%h, need 01/2/deadbeef", obs_rv, obs_rv_cyc, obs_rdata); end
    endtask

    task automatic test_subword();
        logic [31:0] t_addr [7] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h2, 32'h1, 32'h2};
        logic [2:0]  t_size [7] = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b101, 3'b000, 3'b000};
        logic [31:0] t_exp  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                                     32'h0000_80FF, 32'h0000_007F, 32'hFFFF_FFFF};
        logic [3:0]  t_be   [7] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b1100, 4'b0010, 4'b0100};
        set_port(1'b0, 1'b1, 32'h0, 32'h80FF_7F01, 3'b010);
        run_access(2'b01);
        model_store(3'b010, 32'h0, 32'h80FF_7F01);
        for (int i = 0; i < 7; i++) begin
            set_port(1'b0, 1'b0, t_addr[i], 32'h0, t_size[i]);
            run_access(2'b01);
            checks++; if (obs_be !== t_be[i]) begin errors++; $display("FAIL load_be[%0d]: got %b, need %b", i, obs_be, t_be[i]); end
            checks++; if (obs_rdata !== t_exp[i] || obs_err !== 2'b00) begin errors++; $display("FAIL load_rdata[%0d]: got %h err=%b, need %h err=00", i, obs_rdata, obs_err, t_exp[i]); end
        end
        set_port(1'b0, 1'b1, 32'h5, 32'h1111_22AB, 3'b000);
        run_access(2'b01);
        model_store(3'b000, 32'h5, 32'h1111_22AB);
        checks++; if (obs_be !== 4'b0010 || obs_mwdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_lanes: got be=%b wd=%h, need 0010 abababab", obs_be, obs_mwdata); end
        set_port(1'b0, 1'b1, 32'h6, 32'h5555_1234, 3'b001);
        run_access(2'b01);
        model_store(3'b001, 32'h6, 32'h5555_1234);
        checks++; if (obs_be !== 4'b1100 || obs_mwdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_lanes: got be=%b wd=%h, need 1100 12341234", obs_be, obs_mwdata); end
    endtask

    task automatic test_misaligned();
        logic        t_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_addr [4] = '{32'h6, 32'h8, 32'h8, 32'h1};
        logic [2:0]  t_size [4] = '{3'b010, 3'b100, 3'b011, 3'b001};
        for (int i = 0; i < 4; i++) begin
            set_port(1'b0, t_we[i], t_addr[i], 32'hFFFF_FFFF, t_size[i]);
            run_access(2'b01);
            checks++; if (obs_gnt !== 2'b01 || obs_gnt_cyc != 1 || obs_en !== 1'b0 || obs_we !== 1'b0)
                begin errors++; $display("FAIL err_issue[%0d]: got gnt=%b cyc=%0d en=%b we=%b, need 01/1/0/0", i, obs_gnt, obs_gnt_cyc, obs_en, obs_we); end
            checks++; if (obs_rv !== 2'b01 || obs_rv_cyc != 2 || obs_err !== 2'b01 || obs_rdata !== 32'h0)
                begin errors++; $display("FAIL err_resp[%0d]: got rv=%b cyc=%0d err=%b rdata=%h, need 01/2/01/0", i, obs_rv, obs_rv_cyc, obs_err, obs_rdata); end
        end
    endtask

    task automatic test_contention();
        bit exp_seq [6];
        int n = 0;
        int prev_cyc = -1;
`ifdef DATA_ARB_ROUND_ROBIN_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        apply_reset(2);
        set_port(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        set_port(1'b1, 1'b0, 32'h4, 32'h0, 3'b010);
        req = 2'b11;
        for (int cyc = 1; cyc <= 40 && n < 6; cyc++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                checks++; if (gnt !== (2'b01 << exp_seq[n])) begin errors++; $display("FAIL contention_gnt[%0d]: got %b, need %b", n, gnt, 2'b01 << exp_seq[n]); end
                if (n > 0) begin
                    checks++; if (cyc - prev_cyc != 3) begin errors++; $display("FAIL contention_spacing[%0d]: got %0d cycles, need 3", n, cyc - prev_cyc); end
                end
                prev_cyc = cyc;
                n++;
            end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL contention_count: got %0d grants, need 6", n); end
        req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_issue();
        bit saw_rv = 1'b0;
        set_port(1'b0, 1'b1, 32'h21, 32'h0000_005A, 3'b000);
        req = 2'b01;
        @(negedge clk);
        checks++; if ({gnt, mem_en, mem_we, mem_be} !== {2'b01, 1'b1, 1'b1, 4'b0010})
            begin errors++; $display("FAIL mid_issue_strobe: got gnt=%b en=%b we=%b be=%b, need 01/1/1/0010", gnt, mem_en, mem_we, mem_be); end
        checks++; if (mem_addr !== 30'h8 || mem_wdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL mid_issue_data: got maddr=%h wd=%h, need 8 5a5a5a5a", mem_addr, mem_wdata); end
        model_store(3'b000, 32'h21, 32'h5A);
        reset = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        checks++;
        if ({gnt, rvalid, err, rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== '0)
            begin errors++; $display("FAIL mid_reset_outputs: got gnt=%b rv=%b rdata=%h en=%b be=%b maddr=%h mwd=%h, all zero required",
                gnt, rvalid, rdata, mem_en, mem_be, mem_addr, mem_wdata); end
        reset = 1'b1;
        last_grant = 1'b1;
        repeat (3) begin @(negedge clk); if (rvalid != 2'b00) saw_rv = 1'b1; end
        checks++; if (saw_rv) begin errors++; $display("FAIL mid_reset_rvalid: got rvalid after reset, need none"); end

        set_port(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        set_port(1'b1, 1'b0, 32'h4, 32'h0, 3'b010);
        run_access(2'b11);
        last_grant = 1'b0;
        checks++; if (obs_gnt !== 2'b01) begin errors++; $display("FAIL ptr_after_reset: got gnt=%b, need 01", obs_gnt); end
        set_port(1'b0, 1'b0, 32'h21, 32'h0, 3'b100);
        run_access(2'b01);
        checks++; if (obs_rdata !== model_load(3'b100, 32'h21)) begin errors++; $display("FAIL committed_byte: got %h, need %h", obs_rdata, model_load(3'b100, 32'h21)); end
    endtask

    task automatic test_random();
        logic [2:0]  sz_tbl [10] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
        logic [1:0]  mask;
        bit          w;
        logic        ew;
        logic [31:0] ea, ed;
        logic [2:0]  es;
        bit          e;
        for (int i = 0; i < 64; i++) begin
            ed = $urandom;
            set_port(1'b0, 1'b1, 32'(i * 4), ed, 3'b010);
            run_access(2'b01);
            model_store(3'b010, 32'(i * 4), ed);
        end
        apply_reset(1);
        for (int it = 0; it < 60; it++) begin
            for (int r = 0; r < 2; r++) begin
                es = sz_tbl[$urandom_range(0, 9)];
                ea = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0 && nbytes(es) > 1) ea = ea & ~32'(nbytes(es) - 1);
                set_port(r[0], 1'($urandom_range(0, 1)), ea, $urandom, es);
            end
            mask = 2'($urandom_range(1, 3));
            if (mask == 2'b11) begin
`ifdef DATA_ARB_ROUND_ROBIN_EN
                w = ~last_grant;
`else
                w = 1'b0;
`endif
            end else begin
                w = mask[1];
            end
            ew = we[w]; ea = a_addr[w]; ed = a_wdata[w]; es = a_size[w];
            e  = model_err(ew, es, ea);
            run_access(mask);
            last_grant = w;
            checks++; if (obs_gnt !== (2'b01 << w) || obs_gnt_cyc != 1) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b cyc=%0d, need %b cyc=1", it, obs_gnt, obs_gnt_cyc, 2'b01 << w); end
            checks++; if ({obs_en, obs_we} !== {!e, !e && ew}) begin errors++; $display("FAIL rnd_strobe[%0d]: got en/we=%b%b, need %b%b", it, obs_en, obs_we, !e, !e && ew); end
            checks++; if (obs_maddr !== ea[31:2]) begin errors++; $display("FAIL rnd_maddr[%0d]: got %h, need %h", it, obs_maddr, ea[31:2]); end
            if (!e) begin
                checks++; if (obs_be !== model_be(es, ea)) begin errors++; $display("FAIL rnd_be[%0d]: got %b, need %b", it, obs_be, model_be(es, ea)); end
            end
            if (!e && ew) begin
                checks++; if (obs_mwdata !== model_wdata(es, ed)) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h, need %h", it, obs_mwdata, model_wdata(es, ed)); end
                model_store(es, ea, ed);
            end
            checks++; if (obs_rv !== (2'b01 << w) || obs_rv_cyc != 2 || obs_err !== (e ? (2'b01 << w) : 2'b00))
                begin errors++; $display("FAIL rnd_resp[%0d]: got rv=%b cyc=%0d err=%b, need rv=%b cyc=2 err=%b", it, obs_rv, obs_rv_cyc, obs_err, 2'b01 << w, e ? (2'b01 << w) : 2'b00); end
            checks++; if (obs_rdata !== ((!e && !ew) ? model_load(es, ea) : 32'h0))
                begin errors++; $display("FAIL rnd_rdata[%0d]: got %h, need %h", it, obs_rdata, (!e && !ew) ? model_load(es, ea) : 32'h0); end
        end
    endtask

    initial begin
        reset = 1'b0;
        req   = 2'b00;
        we    = 2'b00;
        for (int r = 0; r < 2; r++) begin a_addr[r] = '0; a_wdata[r] = '0; a_size[r] = '0; end
        for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;
        last_grant = 1'b1;
        test_reset();
        test_word_store_load();
        test_subword();
        test_misaligned();
        test_contention();
        test_reset_mid_issue();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
